// File: rtl/gpr_scoreboard_pkg.sv
// Shared CPU timing constants: ready-counter widths, mult/div latencies and
// the hard-wired zero register index. The decoder's Tuse/Tnew tables and the
// mult/div unit import these too.
package gpr_scoreboard_pkg;
  localparam int NREG     = 32;
  localparam int RW       = 5;
  localparam int TW       = 2;
  localparam int MDW      = 4;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam logic [RW-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/gpr_scoreboard_if.sv
// Decode-stage request bundle and scoreboard status back to the pipeline.
interface gpr_scoreboard_if #(
  parameter int NREG = gpr_scoreboard_pkg::NREG,
  parameter int TW   = gpr_scoreboard_pkg::TW
);
  localparam int RW = $clog2(NREG);

  logic          issue_valid;
  logic [RW-1:0] issue_rs;
  logic [RW-1:0] issue_rt;
  logic          use_rs;
  logic          use_rt;
  logic [TW-1:0] tuse_rs;
  logic [TW-1:0] tuse_rt;
  logic [RW-1:0] issue_rd;
  logic [TW-1:0] issue_tnew;
  logic          md_start;
  logic          md_is_div;
  logic          md_op;
  logic          stall;
  logic          md_busy;
  logic [NREG-1:0] busy_mask;

  modport master (
    output issue_valid, issue_rs, issue_rt, use_rs, use_rt, tuse_rs, tuse_rt,
           issue_rd, issue_tnew, md_start, md_is_div, md_op,
    input  stall, md_busy, busy_mask
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt, use_rs, use_rt, tuse_rs, tuse_rt,
           issue_rd, issue_tnew, md_start, md_is_div, md_op,
    output stall, md_busy, busy_mask
  );
endinterface

// File: rtl/gpr_scoreboard_ready_counter.sv
// Saturating down-counter with a load port; load beats decrement.
module ready_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt
);
  // Load a fresh countdown, else count down toward zero and hold there
  always_ff @(posedge clk) begin
    if (reset)         cnt <= '0;
    else if (load)     cnt <= load_val;
    else if (cnt != 0) cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/gpr_scoreboard.sv
// Issue-stage hazard scheduler: per-register forwarding countdowns plus the
// mult/div busy countdown; stall freezes PC/F/D and bubbles E.
module gpr_scoreboard
  import gpr_scoreboard_pkg::*;
#(
  parameter int NREG_P     = NREG,
  parameter int TW_P       = TW,
  parameter int MDW_P      = MDW,
  parameter int MULT_LAT_P = MULT_LAT,
  parameter int DIV_LAT_P  = DIV_LAT
) (
  input  logic            clk,
  input  logic            reset,
  gpr_scoreboard_if.slave sb
);
  localparam int RWP = $clog2(NREG_P);

  if (MULT_LAT_P >= 2**MDW_P || DIV_LAT_P >= 2**MDW_P) begin : g_lat_chk
    $error("mult/div latency does not fit in the md counter");
  end

  logic [NREG_P-1:0][TW_P-1:0] cnt;
  logic [MDW_P-1:0]            md_cnt;
  logic                        rs_haz, rt_haz, md_haz, issue;

  // Hazard comparators use the counter values held at the start of the cycle,
  // so a reader that also writes the same register sees the old countdown.
  always_comb begin
    rs_haz = sb.use_rs && (sb.issue_rs != RWP'(REG_ZERO)) && (cnt[sb.issue_rs] > sb.tuse_rs);
    rt_haz = sb.use_rt && (sb.issue_rt != RWP'(REG_ZERO)) && (cnt[sb.issue_rt] > sb.tuse_rt);
    md_haz = sb.md_op && (md_cnt != '0);
    sb.stall = sb.issue_valid && (rs_haz || rt_haz || md_haz);
    issue    = sb.issue_valid && !sb.stall;
  end

  // $0 never becomes busy
  assign cnt[0]          = '0;
  assign sb.busy_mask[0] = 1'b0;

  for (genvar i = 1; i < NREG_P; i++) begin : g_reg
    ready_counter #(.W(TW_P)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (issue && (sb.issue_rd == RWP'(i))),
      .load_val (sb.issue_tnew),
      .cnt      (cnt[i])
    );
    assign sb.busy_mask[i] = (cnt[i] != '0);
  end

  ready_counter #(.W(MDW_P)) u_md_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (issue && sb.md_start),
    .load_val (sb.md_is_div ? MDW_P'(DIV_LAT_P) : MDW_P'(MULT_LAT_P)),
    .cnt      (md_cnt)
  );

  assign sb.md_busy = (md_cnt != '0);
endmodule

// File: tb/tb_gpr_scoreboard.sv
// Directed bench for gpr_scoreboard: load-use, branch, $0, mult/div, self-write, reset.
module tb_gpr_scoreboard;
  import gpr_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  gpr_scoreboard_if sb_if();

  gpr_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sb_if.issue_valid = 1'b0;
    sb_if.issue_rs    = '0;
    sb_if.issue_rt    = '0;
    sb_if.use_rs      = 1'b0;
    sb_if.use_rt      = 1'b0;
    sb_if.tuse_rs     = '0;
    sb_if.tuse_rt     = '0;
    sb_if.issue_rd    = '0;
    sb_if.issue_tnew  = '0;
    sb_if.md_start    = 1'b0;
    sb_if.md_is_div   = 1'b0;
    sb_if.md_op       = 1'b0;
  endtask

  // Producer of rd with the given tnew and no sources
  task automatic present_writer(input logic [4:0] rd, input logic [1:0] tnew);
    idle_inputs();
    sb_if.issue_valid = 1'b1;
    sb_if.issue_rd    = rd;
    sb_if.issue_tnew  = tnew;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (12) tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (sb_if.busy_mask !== 32'h0) begin n_errors++; $display("FAIL reset_busy_mask: got %h expected %h", sb_if.busy_mask, 32'h0); end
    n_checks++;
    if (sb_if.md_busy !== 1'b0) begin n_errors++; $display("FAIL reset_md_busy: got %b expected 0", sb_if.md_busy); end
    n_checks++;
    if (sb_if.stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b expected 0", sb_if.stall); end
  endtask

  task automatic test_load_use();
    present_writer(5'd1, 2'd2);
    #1;
    n_checks++;
    if (sb_if.stall !== 1'b0) begin n_errors++; $display("FAIL lu_lw_stall: got %b expected 0", sb_if.stall); end
    tick();
    // add $2,$1,$3 with rs needed at E
    idle_inputs();
    sb_if.issue_valid = 1'b1; sb_if.use_rs = 1'b1; sb_if.issue_rs = 5'd1; sb_if.tuse_rs = 2'd1;
    sb_if.use_rt = 1'b1; sb_if.issue_rt = 5'd3; sb_if.tuse_rt = 2'd1;
    sb_if.issue_rd = 5'd2; sb_if.issue_tnew = 2'd1;
    #1;
    n_checks++;
    if (sb_if.busy_mask[1] !== 1'b1) begin n_errors++; $display("FAIL lu_mask_c1: got %b expected 1", sb_if.busy_mask[1]); end
    n_checks++;
    if (sb_if.stall !== 1'b1) begin n_errors++; $display("FAIL lu_stall_c1: got %b expected 1", sb_if.stall); end
    tick();
    n_checks++;
    if (sb_if.busy_mask[1] !== 1'b1) begin n_errors++; $display("FAIL lu_mask_c2: got %b expected 1", sb_if.busy_mask[1]); end
    n_checks++;
    if (sb_if.stall !== 1'b0) begin n_errors++; $display("FAIL lu_stall_c2: got %b expected 0", sb_if.stall); end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (sb_if.busy_mask[1] !== 1'b0) begin n_errors++; $display("FAIL lu_mask_c3: got %b expected 0", sb_if.busy_mask[1]); end
    n_checks++;
    if (sb_if.busy_mask[2] !== 1'b1) begin n_errors++; $display("FAIL lu_add_issued: got %b expected 1", sb_if.busy_mask[2]); end
    drain();
  endtask

  task automatic test_branch();
    int stalls = 0;
    present_writer(5'd1, 2'd2);
    tick();
    idle_inputs();
    sb_if.issue_valid = 1'b1; sb_if.use_rs = 1'b1; sb_if.issue_rs = 5'd1; sb_if.tuse_rs = 2'd0;
    #1;
    while (sb_if.stall && stalls < 10) begin
      stalls++;
      tick();
    end
    n_checks++;
    if (stalls !== 2) begin n_errors++; $display("FAIL branch_stall_cycles: got %0d expected 2", stalls); end
    drain();
  endtask

  task automatic test_zero_reg();
    present_writer(5'd0, 2'd1);
    tick();
    idle_inputs();
    sb_if.issue_valid = 1'b1; sb_if.use_rs = 1'b1; sb_if.issue_rs = 5'd0;
    sb_if.use_rt = 1'b1; sb_if.issue_rt = 5'd0;
    #1;
    n_checks++;
    if (sb_if.busy_mask !== 32'h0) begin n_errors++; $display("FAIL zero_busy_mask: got %h expected %h", sb_if.busy_mask, 32'h0); end
    n_checks++;
    if (sb_if.stall !== 1'b0) begin n_errors++; $display("FAIL zero_stall: got %b expected 0", sb_if.stall); end
    drain();
  endtask

  task automatic test_mult_div(input logic is_div, input int exp_lat);
    int stalls = 0;
    idle_inputs();
    sb_if.issue_valid = 1'b1; sb_if.md_start = 1'b1; sb_if.md_op = 1'b1; sb_if.md_is_div = is_div;
    #1;
    n_checks++;
    if (sb_if.stall !== 1'b0) begin n_errors++; $display("FAIL md_start_stall div=%b: got %b expected 0", is_div, sb_if.stall); end
    tick();
    idle_inputs();
    sb_if.issue_valid = 1'b1; sb_if.md_op = 1'b1;
    #1;
    n_checks++;
    if (sb_if.md_busy !== 1'b1) begin n_errors++; $display("FAIL md_busy_first div=%b: got %b expected 1", is_div, sb_if.md_busy); end
    while (sb_if.stall && stalls < 20) begin
      stalls++;
      tick();
    end
    n_checks++;
    if (stalls !== exp_lat) begin n_errors++; $display("FAIL md_stall_cycles div=%b: got %0d expected %0d", is_div, stalls, exp_lat); end
    n_checks++;
    if (sb_if.md_busy !== 1'b0) begin n_errors++; $display("FAIL md_busy_end div=%b: got %b expected 0", is_div, sb_if.md_busy); end
    drain();
  endtask

  task automatic test_self_write();
    present_writer(5'd4, 2'd2);
    tick();
    idle_inputs();
    tick();
    // cnt[4] is 1 now: addu $4,$4,$5, rs needed at E
    idle_inputs();
    sb_if.issue_valid = 1'b1; sb_if.use_rs = 1'b1; sb_if.issue_rs = 5'd4; sb_if.tuse_rs = 2'd1;
    sb_if.use_rt = 1'b1; sb_if.issue_rt = 5'd5; sb_if.tuse_rt = 2'd1;
    sb_if.issue_rd = 5'd4; sb_if.issue_tnew = 2'd2;
    #1;
    n_checks++;
    if (sb_if.stall !== 1'b0) begin n_errors++; $display("FAIL self_stall: got %b expected 0", sb_if.stall); end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (sb_if.busy_mask[4] !== 1'b1) begin n_errors++; $display("FAIL self_mask_e1: got %b expected 1", sb_if.busy_mask[4]); end
    tick();
    n_checks++;
    if (sb_if.busy_mask[4] !== 1'b1) begin n_errors++; $display("FAIL self_mask_e2: got %b expected 1", sb_if.busy_mask[4]); end
    tick();
    n_checks++;
    if (sb_if.busy_mask[4] !== 1'b0) begin n_errors++; $display("FAIL self_mask_e3: got %b expected 0", sb_if.busy_mask[4]); end
    drain();
  endtask

  task automatic test_mid_reset();
    idle_inputs();
    sb_if.issue_valid = 1'b1; sb_if.md_start = 1'b1; sb_if.md_op = 1'b1; sb_if.md_is_div = 1'b1;
    tick();
    idle_inputs();
    tick();
    present_writer(5'd7, 2'd2);
    tick();
    // cnt[7]=2, md_cnt=8: a reader of $7 at D must stall here
    idle_inputs();
    sb_if.issue_valid = 1'b1; sb_if.use_rs = 1'b1; sb_if.issue_rs = 5'd7;
    #1;
    n_checks++;
    if (sb_if.stall !== 1'b1) begin n_errors++; $display("FAIL mr_pre_stall: got %b expected 1", sb_if.stall); end
    n_checks++;
    if (sb_if.busy_mask !== 32'h0000_0080) begin n_errors++; $display("FAIL mr_pre_mask: got %h expected %h", sb_if.busy_mask, 32'h80); end
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_if.issue_valid = 1'b1; sb_if.use_rs = 1'b1; sb_if.issue_rs = 5'd7;
    #1;
    n_checks++;
    if (sb_if.busy_mask !== 32'h0) begin n_errors++; $display("FAIL mr_mask: got %h expected %h", sb_if.busy_mask, 32'h0); end
    n_checks++;
    if (sb_if.md_busy !== 1'b0) begin n_errors++; $display("FAIL mr_md_busy: got %b expected 0", sb_if.md_busy); end
    n_checks++;
    if (sb_if.stall !== 1'b0) begin n_errors++; $display("FAIL mr_reader_stall: got %b expected 0", sb_if.stall); end
    idle_inputs();
    sb_if.issue_valid = 1'b1; sb_if.md_op = 1'b1;
    #1;
    n_checks++;
    if (sb_if.stall !== 1'b0) begin n_errors++; $display("FAIL mr_mfhi_stall: got %b expected 0", sb_if.stall); end
    drain();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_use();
    test_branch();
    test_zero_reg();
    test_mult_div(1'b0, 5);
    test_mult_div(1'b1, 10);
    test_self_write();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
